// File: rtl/output_select_sequencer.sv
// output_select_sequencer
//
// Emits a sequence of count_i beats. Each beat carries a NUM_WORDS-bit select
// mask and a WORD_W*NUM_WORDS-bit block in which word j is the latched Y1 when
// mask bit j is set and the latched Y0 otherwise. Beats leave through a
// valid/ready handshake at up to one beat per cycle.
//
// Build option:
//   OUTPUT_SELECT_GRAY_EN  defined   -> mask = base ^ gray(k)
//                          undefined -> mask = base + k (wraps mod 2^NUM_WORDS)
//
// Ports:
//   clk_i        in   clock, rising edge
//   rst_n_i      in   asynchronous active-low reset
//   start_i      in   request a new sequence (honoured only in IDLE)
//   Y0_i         in   word used where the mask bit is 0
//   Y1_i         in   word used where the mask bit is 1
//   base_mask_i  in   mask of beat 0
//   count_i      in   number of beats (0 gives a bare done pulse)
//   out_ready_i  in   downstream accepts the current beat
//   out_valid_o  out  current beat is valid
//   output_o     out  assembled block, word j at [WORD_W*(j+1)-1 : WORD_W*j]
//   mask_o       out  select mask of the current beat
//   busy_o       out  sequence in flight (state RUN)
//   done_o       out  one-cycle pulse when a sequence completes
//
// state | meaning
// IDLE  | waiting for start_i
// RUN   | presenting beats, out_valid_o high
// DONE  | one-cycle completion pulse, start_i ignored

module output_select_sequencer #(
    parameter int WORD_W    = 64,
    parameter int NUM_WORDS = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        start_i,
    input  logic [WORD_W-1:0]           Y0_i,
    input  logic [WORD_W-1:0]           Y1_i,
    input  logic [NUM_WORDS-1:0]        base_mask_i,
    input  logic [NUM_WORDS:0]          count_i,
    input  logic                        out_ready_i,
    output logic                        out_valid_o,
    output logic [WORD_W*NUM_WORDS-1:0] output_o,
    output logic [NUM_WORDS-1:0]        mask_o,
    output logic                        busy_o,
    output logic                        done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WORD_W-1:0]           y0_q, y1_q;
    logic [NUM_WORDS-1:0]        base_q;
    logic [NUM_WORDS:0]          k_q;
    logic [NUM_WORDS:0]          remain_q;
    logic [NUM_WORDS-1:0]        mask_q;
    logic [WORD_W*NUM_WORDS-1:0] out_q;

    logic                        accept;
    logic                        xfer;
    logic                        last_beat;
    logic                        load;
    logic [NUM_WORDS:0]          k_inc;
    logic [NUM_WORDS-1:0]        mask_next;
    logic [WORD_W-1:0]           y0_sel, y1_sel;
    logic [WORD_W*NUM_WORDS-1:0] out_next;

    assign accept    = (state == IDLE) && start_i && (count_i != '0);
    assign xfer      = (state == RUN) && out_ready_i;
    // remain_q counts down the beats still to transfer, so 1 marks the last
    assign last_beat = (remain_q == {{NUM_WORDS{1'b0}}, 1'b1});
    // block registers only move on a new sequence or on a non-final transfer;
    // after the final beat they hold their last value
    assign load      = accept || (xfer && !last_beat);
    assign k_inc     = k_q + 1'b1;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_next = (count_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (xfer && last_beat) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Mask and block for the next presented beat. On accept the words come
    // straight from the inputs since the holding registers load in the same edge.
    always_comb begin
        mask_next = mask_q;
        y0_sel    = y0_q;
        y1_sel    = y1_q;
        if (accept) begin
            mask_next = base_mask_i;
            y0_sel    = Y0_i;
            y1_sel    = Y1_i;
        end else begin
`ifdef OUTPUT_SELECT_GRAY_EN
            mask_next = NUM_WORDS'({1'b0, base_q} ^ (k_inc ^ (k_inc >> 1)));
`else
            mask_next = NUM_WORDS'({1'b0, base_q} + k_inc);
`endif
        end
    end

    always_comb begin
        out_next = '0;
        for (int j = 0; j < NUM_WORDS; j++) begin
            out_next[j*WORD_W +: WORD_W] = mask_next[j] ? y1_sel : y0_sel;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            y0_q     <= '0;
            y1_q     <= '0;
            base_q   <= '0;
            k_q      <= '0;
            remain_q <= '0;
            mask_q   <= '0;
            out_q    <= '0;
        end else begin
            if (accept) begin
                y0_q     <= Y0_i;
                y1_q     <= Y1_i;
                base_q   <= base_mask_i;
                k_q      <= '0;
                remain_q <= count_i;
            end else if (xfer) begin
                k_q      <= k_inc;
                remain_q <= remain_q - 1'b1;
            end
            if (load) begin
                mask_q <= mask_next;
                out_q  <= out_next;
            end
        end
    end

    assign out_valid_o = (state == RUN);
    assign busy_o      = (state == RUN);
    assign done_o      = (state == DONE);
    assign mask_o      = mask_q;
    assign output_o    = out_q;

endmodule

// File: tb/tb_output_select_sequencer.sv
// Directed bench for output_select_sequencer. Each issued sequence pushes its
// hand-computed beats into a scoreboard queue; a monitor on the falling edge
// compares every presented beat with the queue head and pops it on transfer.
module tb_output_select_sequencer;

    localparam int WW = 64;
    localparam int NW = 16;
`ifdef OUTPUT_SELECT_GRAY_EN
    localparam bit GRAY = 1'b1;
`else
    localparam bit GRAY = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [WW-1:0]     y0, y1;
    logic [NW-1:0]     base;
    logic [NW:0]       count;
    logic              ready;
    logic              valid;
    logic [WW*NW-1:0]  out_blk;
    logic [NW-1:0]     mask;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    output_select_sequencer #(.WORD_W(WW), .NUM_WORDS(NW)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .start_i     (start),
        .Y0_i        (y0),
        .Y1_i        (y1),
        .base_mask_i (base),
        .count_i     (count),
        .out_ready_i (ready),
        .out_valid_o (valid),
        .output_o    (out_blk),
        .mask_o      (mask),
        .busy_o      (busy),
        .done_o      (done)
    );

    typedef struct {
        logic [NW-1:0] mask;
        logic [WW-1:0] y0;
        logic [WW-1:0] y1;
    } beat_t;

    beat_t sbq[$];
    int vectors     = 0;
    int miscompares = 0;
    int exp_done    = 0;
    int got_done    = 0;

    localparam logic [WW-1:0] A0 = 64'h0123_4567_89AB_CDEF;
    localparam logic [WW-1:0] A1 = 64'hFEDC_BA98_7654_3210;

    function automatic logic [WW*NW-1:0] build(input beat_t b);
        logic [WW*NW-1:0] r;
        r = '0;
        for (int j = 0; j < NW; j++) r[j*WW +: WW] = b.mask[j] ? b.y1 : b.y0;
        return r;
    endfunction

    task automatic chk(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [NW-1:0] m, input logic [WW-1:0] a, input logic [WW-1:0] b);
        beat_t e;
        e.mask = m;
        e.y0   = a;
        e.y1   = b;
        sbq.push_back(e);
    endtask

    // Called at posedge+1; start is sampled on the following edge, then the
    // inputs are scrambled so a re-latch would show up as wrong beats.
    task automatic issue(input logic [NW-1:0] b, input logic [NW:0] c,
                         input logic [WW-1:0] a0, input logic [WW-1:0] a1);
        y0 = a0; y1 = a1; base = b; count = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        y0 = ~a0; y1 = ~a1; base = ~b; count = 17'd7;
    endtask

    // Edges counted after the start edge until done_o is seen. poke raises
    // start once mid-RUN and once during DONE; both must be ignored.
    task automatic wait_done(input string name, input int exp_n,
                             input int stall_at, input int stall_len, input bit poke);
        int n;
        n = 0;
        while (!done && n < 300) begin
            if (n == stall_at) ready = 1'b0;
            if (n == stall_at + stall_len) ready = 1'b1;
            if (poke && n == 1) begin start = 1'b1; count = 17'd2; base = 16'h5555; end
            if (poke && n == 2) start = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        ready = 1'b1;
        exp_done++;
        chk(done, {name, "_done_seen"}, 64'(done), 64'd1);
        chk(n == exp_n, {name, "_done_latency"}, 64'(n), 64'(exp_n));
        if (poke) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk(!done, {name, "_done_one_cycle"}, 64'(done), 64'd0);
        chk(!busy, {name, "_idle_after_done"}, 64'(busy), 64'd0);
        chk(sbq.size() == 0, {name, "_all_beats"}, 64'(sbq.size()), 64'd0);
        if (poke) begin
            @(posedge clk); #1;
            chk(!busy, {name, "_start_in_done_ignored"}, 64'(busy), 64'd0);
        end
    endtask

    // Monitor
    beat_t            mb;
    logic [WW*NW-1:0] me;
    int               mw;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (valid) begin
                    if (sbq.size() == 0) begin
                        chk(1'b0, "unexpected_beat", 64'(mask), 64'd0);
                    end else begin
                        mb = sbq[0];
                        me = build(mb);
                        mw = 0;
                        for (int j = NW - 1; j >= 0; j--)
                            if (out_blk[j*WW +: WW] !== me[j*WW +: WW]) mw = j;
                        chk(mask === mb.mask, "beat_mask", 64'(mask), 64'(mb.mask));
                        chk(out_blk === me, $sformatf("beat_output_word%0d", mw),
                            out_blk[mw*WW +: WW], me[mw*WW +: WW]);
                        chk(busy, "busy_with_valid", 64'(busy), 64'd1);
                        if (ready) void'(sbq.pop_front());
                    end
                end
                if (done) got_done++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; ready = 1'b1;
        y0 = '0; y1 = '0; base = '0; count = '0;
        repeat (3) @(posedge clk);
        #1;
        chk(!valid, "rst_valid", 64'(valid), 64'd0);
        chk(!busy,  "rst_busy",  64'(busy),  64'd0);
        chk(!done,  "rst_done",  64'(done),  64'd0);
        chk(mask == '0, "rst_mask", 64'(mask), 64'd0);
        chk(out_blk == '0, "rst_output", out_blk[63:0], 64'd0);
        rst_n = 1'b1;

        // basic sequence, issued on the first edge after reset release
        push(16'h0000, '0, '1);
        push(16'h0001, '0, '1);
        push(GRAY ? 16'h0003 : 16'h0002, '0, '1);
        issue(16'h0000, 17'd3, '0, '1);
        wait_done("basic", 3, -1, 0, 1'b0);

        // wrap past all-ones
        push(16'hFFFE, A0, A1);
        push(16'hFFFF, A0, A1);
        push(GRAY ? 16'hFFFD : 16'h0000, A0, A1);
        push(GRAY ? 16'hFFFC : 16'h0001, A0, A1);
        issue(16'hFFFE, 17'd4, A0, A1);
        wait_done("wrap", 4, -1, 0, 1'b0);

        // ready low for 3 cycles while beat 2 is presented
        push(16'h00F0, A1, A0);
        push(16'h00F1, A1, A0);
        push(GRAY ? 16'h00F3 : 16'h00F2, A1, A0);
        push(GRAY ? 16'h00F2 : 16'h00F3, A1, A0);
        push(GRAY ? 16'h00F6 : 16'h00F4, A1, A0);
        issue(16'h00F0, 17'd5, A1, A0);
        wait_done("stall", 8, 2, 3, 1'b0);

        // zero count: no beats, immediate done
        issue(16'h1234, 17'd0, A0, A1);
        wait_done("zero", 0, -1, 0, 1'b0);

        // start during RUN and during DONE is ignored
        push(16'h0100, 64'h5, 64'hA);
        push(16'h0101, 64'h5, 64'hA);
        push(GRAY ? 16'h0103 : 16'h0102, 64'h5, 64'hA);
        issue(16'h0100, 17'd3, 64'h5, 64'hA);
        wait_done("ignore_start", 3, -1, 0, 1'b1);

        // reset while beat 7 of 20 is presented
        for (int i = 0; i < 20; i++) begin
            logic [NW-1:0] g;
            g = NW'(i) ^ (NW'(i) >> 1);
            push(GRAY ? g : NW'(i), A0, A1);
        end
        issue(16'h0000, 17'd20, A0, A1);
        repeat (7) begin
            @(posedge clk); #1;
        end
        chk(mask == (GRAY ? 16'h0004 : 16'h0007), "pre_reset_beat7", 64'(mask),
            GRAY ? 64'h4 : 64'h7);
        rst_n = 1'b0;
        #1;
        chk(!valid, "midrst_valid", 64'(valid), 64'd0);
        chk(!busy,  "midrst_busy",  64'(busy),  64'd0);
        chk(!done,  "midrst_done",  64'(done),  64'd0);
        chk(mask == '0, "midrst_mask", 64'(mask), 64'd0);
        chk(out_blk == '0, "midrst_output", out_blk[63:0], 64'd0);
        sbq.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        push(16'h8000, A1, A0);
        push(16'h8001, A1, A0);
        issue(16'h8000, 17'd2, A1, A0);
        wait_done("after_reset", 2, -1, 0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk(got_done == exp_done, "done_pulse_count", 64'(got_done), 64'(exp_done));
        chk(sbq.size() == 0, "scoreboard_empty", 64'(sbq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
